// File: rtl/add_sub_pipe.sv
// Pipelined N-bit adder/subtractor: the carry chain is split into STAGES chunks
// of W bits, one chunk per register stage, with a valid/ready handshake on both ends.
`timescale 1ns/1ps

module add_sub_pipe #(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W = (STAGES >= 1) ? N / STAGES : N;

  if (STAGES < 1 || (N % STAGES) != 0) begin : g_bad_cfg
    $fatal(1, "add_sub_pipe: N (%0d) must be a positive multiple of STAGES (%0d)", N, STAGES);
  end

  logic                       adv;
  logic [STAGES-1:0]          valid_q, valid_d, src_valid;
  logic [STAGES-1:0][N-1:0]   a_q, a_d, src_a;
  logic [STAGES-1:0][N-1:0]   b_q, b_d, src_b;
  logic [STAGES-1:0][N-1:0]   res_q, res_d, src_res;
  logic [STAGES-1:0]          carry_q, carry_d, src_carry;
  logic                       ovf_q, ovf_d;
  logic                       zero_q, zero_d;
  logic [W:0]                 sum;

  assign adv      = !valid_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  // Stage k is fed by register k-1; stage 0 is fed directly by the inputs
  // with b already inverted for subtraction and carry-in = sub.
  always_comb begin
    src_valid = '0;
    src_a     = '0;
    src_b     = '0;
    src_res   = '0;
    src_carry = '0;
    src_valid[0] = in_valid;
    src_a[0]     = a;
    src_b[0]     = b ^ {N{sub}};
    src_carry[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_a[k]     = a_q[k-1];
      src_b[k]     = b_q[k-1];
      src_res[k]   = res_q[k-1];
      src_carry[k] = carry_q[k-1];
    end
  end

  // Data registers only load behind a valid token, so bubbles never disturb
  // the held result and idle operands cannot reach any output.
  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    sum     = '0;
    if (adv) begin
      valid_d = src_valid;
      for (int k = 0; k < STAGES; k++) begin
        sum = {1'b0, src_a[k][k*W +: W]} + {1'b0, src_b[k][k*W +: W]} + {{W{1'b0}}, src_carry[k]};
        if (src_valid[k]) begin
          a_d[k]                = src_a[k];
          b_d[k]                = src_b[k];
          res_d[k]              = src_res[k];
          res_d[k][k*W +: W]    = sum[W-1:0];
          carry_d[k]            = sum[W];
          // Same-sign operands giving an opposite-sign result == carry into MSB xor carry out.
          if (k == STAGES - 1) begin
            ovf_d  = (src_a[k][N-1] == src_b[k][N-1]) && (sum[W-1] != src_a[k][N-1]);
            zero_d = (res_d[k] == '0);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign out       = res_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Operand copies in the last stage have no consumer; they are kept only so
  // every stage has the same shape and synthesis trims them.
  logic unused_bits;
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1]};

endmodule
